// File: rtl/timer_counter.sv
// -----------------------------------------------------------------------------
// timer_counter
//
// Memory-mapped down-counting timer on the CPU data bus. The CPU programs the
// control and preset registers and reads back the live count. An interrupt
// request is raised when the count expires.
//
// Register map (byte offsets from BASE_ADDR, word accesses only):
//   0x0  CTRL    [0] en, [2:1] mode (01 auto-reload, otherwise one-shot),
//                [3] im (interrupt mask), [31:4] read as zero
//   0x4  PRESET  reload value, fully writable
//   0x8  COUNT   current count, read-only
//   0xC  reserved, reads zero, writes ignored
//
// Ports:
//   clk    system clock, rising edge
//   reset  synchronous active-high reset
//   addr   byte address from the CPU; bits [1:0] are ignored
//   we     write strobe, one cycle per store
//   wdata  store data
//   rdata  load data, combinational from addr
//   irq    interrupt request (im & expiry flag)
//
// BASE_ADDR must be 16-byte aligned; its low four bits are not decoded.
// -----------------------------------------------------------------------------
module timer_counter #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_7F00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic        we,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CNT  = 2'd2,
        INT  = 2'd3
    } state_e;

    typedef struct packed {
        logic       im;
        logic [1:0] mode;
        logic       en;
    } ctrl_t;

    localparam logic [1:0] OFF_CTRL    = 2'd0;
    localparam logic [1:0] OFF_PRESET  = 2'd1;
    localparam logic [1:0] OFF_COUNT   = 2'd2;
    localparam logic [1:0] MODE_RELOAD = 2'b01;

    state_e      state_q,    state_d;
    ctrl_t       ctrl_q,     ctrl_d;
    logic [31:0] preset_q,   preset_d;
    logic [31:0] count_q,    count_d;
    logic        irq_flag_q, irq_flag_d;

    logic        sel;
    logic [1:0]  off;
    logic        unused_addr_bits;

    assign sel = (addr[31:4] == BASE_ADDR[31:4]);
    assign off = addr[3:2];

    // Byte-lane bits are deliberately not decoded.
    assign unused_addr_bits = ^addr[1:0];

    // -------------------------------------------------------------------------
    // Next-state logic: FSM first, then CPU writes, so that a CPU write to
    // CTRL overrides the en clear made by INT in the same cycle.
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it
        // unassigned; otherwise synthesis would infer a latch.
        state_d    = state_q;
        ctrl_d     = ctrl_q;
        preset_d   = preset_q;
        count_d    = count_q;
        irq_flag_d = irq_flag_q;

        unique case (state_q)
            IDLE: begin
                if (ctrl_q.en) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                count_d    = preset_q;
                irq_flag_d = 1'b0;
                state_d    = CNT;
            end
            CNT: begin
                if (!ctrl_q.en) begin
                    state_d = IDLE;
                end else if (count_q > 32'd1) begin
                    count_d = count_q - 32'd1;
                end else begin
                    // Covers a preset of 0 too, so the count never wraps.
                    count_d    = '0;
                    irq_flag_d = 1'b1;
                    state_d    = INT;
                end
            end
            INT: begin
                if (ctrl_q.mode == MODE_RELOAD) begin
                    irq_flag_d = 1'b0;
                    state_d    = LOAD;
                end else begin
                    // One-shot: flag stays up until a CTRL write or LOAD.
                    ctrl_d.en = 1'b0;
                    state_d   = IDLE;
                end
            end
        endcase

        if (we && sel) begin
            case (off)
                OFF_CTRL: begin
                    ctrl_d     = ctrl_t'(wdata[3:0]);
                    irq_flag_d = 1'b0;
                end
                OFF_PRESET: preset_d = wdata;
                default: ;  // COUNT and reserved offset are read-only
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // State registers. Reset dominates any simultaneous CPU write.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples its pre-edge value regardless of statement order.
        if (reset) begin
            state_q    <= IDLE;
            ctrl_q     <= '0;
            preset_q   <= '0;
            count_q    <= '0;
            irq_flag_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ctrl_q     <= ctrl_d;
            preset_q   <= preset_d;
            count_q    <= count_d;
            irq_flag_q <= irq_flag_d;
        end
    end

    // -------------------------------------------------------------------------
    // Read mux and interrupt output.
    // -------------------------------------------------------------------------
    always_comb begin
        rdata = '0;
        if (sel) begin
            case (off)
                OFF_CTRL:   rdata = {28'd0, ctrl_q};
                OFF_PRESET: rdata = preset_q;
                OFF_COUNT:  rdata = count_q;
                default:    rdata = '0;
            endcase
        end
    end

    assign irq = ctrl_q.im & irq_flag_q;

endmodule

// File: tb/tb_timer_counter.sv
// -----------------------------------------------------------------------------
// tb_timer_counter
//
// Drives directed register-level scenarios followed by randomized bus traffic
// into timer_counter. A behavioural reference model predicts, for every cycle,
// the load data and irq level; predictions go into a scoreboard queue and a
// separate monitor compares them against the DUT on the falling edge.
// -----------------------------------------------------------------------------
module tb_timer_counter;

    localparam logic [31:0] BASE = 32'h0000_7F00;

    logic        clk;
    logic        reset;
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        irq;

    timer_counter #(.BASE_ADDR(BASE)) dut (
        .clk   (clk),
        .reset (reset),
        .addr  (addr),
        .we    (we),
        .wdata (wdata),
        .rdata (rdata),
        .irq   (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // -------------------------------------------------------------------------
    // Scoreboard
    // -------------------------------------------------------------------------
    typedef struct {
        logic [31:0] rdata;
        logic        irq;
        int          cyc;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    task automatic check(input string name, input int at_cyc,
                         input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, at_cyc, got, exp);
        end
    endtask

    // Monitor: outputs are combinational, so one prediction per cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("rdata", e.cyc, rdata, e.rdata);
                check("irq", e.cyc, {31'd0, irq}, {31'd0, e.irq});
            end
        end
    end

    // -------------------------------------------------------------------------
    // Reference model: the timer described as "what is pending" rather than
    // as a state register. At most one of load_pending/running/expired is set;
    // none set means the timer is idle.
    // -------------------------------------------------------------------------
    bit        m_en, m_im;
    bit [1:0]  m_mode;
    bit [31:0] m_preset, m_count;
    bit        m_flag;
    bit        m_load_pending, m_running, m_expired;

    function automatic logic [31:0] model_rdata(input logic [31:0] a);
        if (a[31:4] != BASE[31:4]) return 32'd0;
        case (a[3:2])
            2'd0:    return {28'd0, m_im, m_mode, m_en};
            2'd1:    return m_preset;
            2'd2:    return m_count;
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_step(input logic rst, input logic [31:0] a,
                              input logic w, input logic [31:0] d);
        bit old_en;
        if (rst) begin
            m_en = 0; m_im = 0; m_mode = 0; m_preset = 0; m_count = 0;
            m_flag = 0; m_load_pending = 0; m_running = 0; m_expired = 0;
            return;
        end
        old_en = m_en;
        if (m_load_pending) begin
            m_count        = m_preset;
            m_flag         = 0;
            m_load_pending = 0;
            m_running      = 1;
        end else if (m_running) begin
            if (!old_en) begin
                m_running = 0;              // paused: count frozen
            end else if (m_count > 1) begin
                m_count = m_count - 1;
            end else begin
                m_count   = 0;
                m_flag    = 1;
                m_running = 0;
                m_expired = 1;
            end
        end else if (m_expired) begin
            m_expired = 0;
            if (m_mode == 2'b01) begin
                m_flag         = 0;
                m_load_pending = 1;
            end else begin
                m_en = 0;
            end
        end else if (old_en) begin
            m_load_pending = 1;
        end
        if (w && a[31:4] == BASE[31:4]) begin
            if (a[3:2] == 2'd0) begin
                m_en   = d[0];
                m_mode = d[2:1];
                m_im   = d[3];
                m_flag = 0;
            end else if (a[3:2] == 2'd1) begin
                m_preset = d;
            end
        end
    endtask

    // -------------------------------------------------------------------------
    // Stimulus helpers: one call = one clock cycle.
    // -------------------------------------------------------------------------
    task automatic cycle(input logic rst, input logic [31:0] a, input logic w,
                         input logic [31:0] d, input bit chk);
        exp_t e;
        reset = rst; addr = a; we = w; wdata = d;
        if (chk) begin
            e.rdata = model_rdata(a);
            e.irq   = m_im & m_flag;
            e.cyc   = cyc;
            sb_q.push_back(e);
        end
        @(posedge clk);
        #1;
        model_step(rst, a, w, d);
        cyc++;
    endtask

    task automatic wr(input logic [31:0] off, input logic [31:0] d);
        cycle(1'b0, BASE + off, 1'b1, d, 1'b1);
    endtask

    task automatic rd(input logic [31:0] off);
        cycle(1'b0, BASE + off, 1'b0, 32'd0, 1'b1);
    endtask

    task automatic rd_n(input logic [31:0] off, input int n);
        for (int i = 0; i < n; i++) rd(off);
    endtask

    task automatic do_reset();
        cycle(1'b1, BASE, 1'b0, 32'd0, 1'b1);
    endtask

    // -------------------------------------------------------------------------
    // Test sequence
    // -------------------------------------------------------------------------
    initial begin
        int budget;
        logic [31:0] a, d;
        int r;

        reset = 1'b1; addr = '0; we = 1'b0; wdata = '0;
        cycle(1'b1, BASE, 1'b0, 32'd0, 1'b0);    // DUT state unknown before this
        rd(0); rd(4); rd(8);

        // Reset overrides programmed state
        wr(0, 32'hF); wr(4, 32'd5); rd_n(8, 3);
        do_reset();
        rd(0); rd(4); rd(8); rd(12);

        // One-shot with interrupt enabled
        wr(4, 32'd3); wr(0, 32'h9);
        rd_n(8, 5); rd_n(0, 3);
        wr(0, 32'h8); rd(0); rd(8);

        // Auto-reload, period preset+2
        wr(4, 32'd3); wr(0, 32'hB);
        rd_n(8, 17);
        wr(0, 32'h0); rd(8);

        // Masked one-shot
        wr(4, 32'd2); wr(0, 32'h1);
        rd_n(8, 5); rd_n(0, 2);

        // Pause and resume
        wr(4, 32'd10); wr(0, 32'h9);
        budget = 40;
        while (m_count != 32'd6 && budget > 0) begin
            rd(8);
            budget--;
        end
        if (budget == 0) check("pause_reach_6", cyc, m_count, 32'd6);
        wr(0, 32'h8); rd_n(8, 4);
        wr(4, 32'd4); wr(0, 32'h9);
        rd_n(8, 8); rd(0);

        // preset of zero behaves as one
        wr(4, 32'd0); wr(0, 32'h9); rd_n(8, 5);

        // Decode: read-only, reserved and out-of-window accesses
        wr(8, 32'hDEAD_BEEF); wr(12, 32'h1234_5678); wr(16, 32'hFFFF_FFFF);
        rd(0); rd(4); rd(8); rd(12); rd(16);
        wr(0, 32'hFFFF_FFF0 | 32'h1); rd(0);
        wr(0, 32'h0); rd(0);

        // CTRL write colliding with one-shot expiry clear
        wr(4, 32'd1); wr(0, 32'h9); rd(8); rd(8); rd(8);
        wr(0, 32'hF); rd_n(0, 4);
        wr(0, 32'h0);

        // Randomized bus traffic
        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(0, 9);
            if (r < 8)       a = BASE + 32'(4 * (r % 4));
            else if (r == 8) a = BASE + 32'h10 + 32'(4 * $urandom_range(0, 3));
            else             a = $urandom();
            if ($urandom_range(0, 99) == 0) begin
                cycle(1'b1, a, 1'($urandom_range(0, 1)), $urandom(), 1'b1);
            end else if ($urandom_range(0, 3) == 0) begin
                d = (a[3:2] == 2'd1) ? 32'($urandom_range(0, 12)) : $urandom();
                cycle(1'b0, a, 1'b1, d, 1'b1);
            end else begin
                cycle(1'b0, a, 1'b0, $urandom(), 1'b1);
            end
        end

        // Drain the scoreboard with a bounded wait
        budget = 5;
        while (sb_q.size() > 0 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        @(posedge clk);
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d predictions left, expected 0", sb_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
